csr_machine: RTL and testbench
==============================

Name: csr_machine

Overview:
- Machine-mode CSR file for the pipelined 64-bit RISC-V core.
- Holds mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, misa and mhartid.
- Executes csrrw/csrrs/csrrc accesses from the execute stage.
- Performs the architectural state update on trap entry and on mret.
- Feeds the exception controller: global MIE bit, enabled-interrupt mask, and the trap/return target PC for the fetch stage.

Parameters:
- N, 64, data width of every CSR and PC.
- MISA_VAL, 64'h8000_0000_0000_0100, constant returned on misa reads (RV64I).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- csr_op  in  2  CSR operation: 00 none, 01 RW, 10 RS (set), 11 RC (clear).
- csr_addr  in  12  CSR address.
- csr_wdata  in  N  rs1 value or zero-extended immediate.
- csr_src_zero  in  1  source is x0 or imm=0; for RS/RC this means no write.
- csr_rdata  out  N  old value of the addressed CSR (combinational).
- csr_illegal  out  1  access faults: unknown address, or write to a read-only CSR.
- irq_pending  in  N  live pending-interrupt vector; read through mip.
- trap_valid  in  1  take trap this cycle.
- trap_cause  in  N  cause; bit N-1 set means interrupt.
- trap_pc  in  N  PC of the trapping instruction.
- trap_tval  in  N  faulting address or instruction.
- mret  in  1  mret committed this cycle.
- retire  in  1  one instruction retired this cycle.
- redirect_pc  out  N  trap target when trap_valid, else mepc.
- mstatus_mie  out  1  mstatus.MIE.
- mie_out  out  N  mie register.

Behaviour:
- Reset (async): all registers cleared to 0, except:
  - mstatus.MPP reads 2'b11 (hardwired).
  - mtvec resets to 0.
- Resulting output values during reset:
  - mstatus_mie=0, mie_out=0.
  - redirect_pc=0.
  - csr_rdata reflects the addressed register's reset value.
  - csr_illegal = 0 while csr_op=00.
- Reads are combinational and have zero latency.
- All writes take effect on the rising clk edge; the new value is visible the following cycle.
- Address map:
  - 300 mstatus, 301 misa (RO), 304 mie, 305 mtvec, 340 mscratch, 341 mepc, 342 mcause, 343 mtval, 344 mip (RO), F14 mhartid (RO, reads 0).
  - Any other address sets csr_illegal.
- Write value:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
  - RS/RC with csr_src_zero=1 performs no write and is legal on read-only CSRs.
  - RW to a read-only CSR, or RS/RC with csr_src_zero=0 to a read-only CSR, sets csr_illegal and performs no write.
- WARL field rules:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] always reads 11; all other bits read 0.
  - mtvec: bits[1:0] are mode, where only 00 (direct) and 01 (vectored) are kept; a write of 1x stores 00 in the mode field.
  - mepc: bits[1:0] always read 0.
- Trap entry (trap_valid=1), at the clock edge:
  - mepc <= trap_pc with bits[1:0] cleared.
  - mcause <= trap_cause.
  - mtval <= trap_tval.
  - MPIE <= MIE, then MIE <= 0.
- redirect_pc while trap_valid=1:
  - Default: mtvec base ({mtvec[N-1:2],2'b00}).
  - If mode=01 and trap_cause[N-1]=1: base + 4*trap_cause[5:0].
- mret: MIE <= MPIE and MPIE <= 1. redirect_pc = mepc whenever trap_valid=0.
- Simultaneous events, by priority (higher wins):
  - trap_valid is highest: it suppresses both mret and any CSR write in the same cycle. csr_rdata and csr_illegal are still computed.
  - mret beats a CSR write to mstatus. A CSR write to any other CSR proceeds alongside mret.
  - csr_illegal=1 never blocks trap_valid. The fault is reported to the controller, which raises trap_valid in a later cycle.
- Reset asserted mid-operation abandons any pending update; registers return to their reset values immediately.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined:
  - Adds mcycle (B00) and minstret (B02), both N bits and read-write.
  - mcycle increments every cycle; minstret increments when retire=1.
  - Both wrap from all-ones to 0.
  - A CSR write to a counter in the same cycle wins over the increment (the written value is stored, with no +1).
  - A trap in the same cycle does not stop counting.
- Undefined: B00 and B02 are unknown addresses and set csr_illegal.

Test Plan:
- Reset, then read 300 -> csr_rdata = 0x1800; mstatus_mie = 0. Read F14 -> 0. Read 301 -> MISA_VAL.
- RW 305 with 0x8000_0101; then trap_valid with cause 0x8000_0000_0000_0007 and trap_pc=0x40 -> redirect_pc = 0x8000_011C; mepc = 0x40; mcause = cause.
- RS 300 with 0x8 (MIE=1), then trap -> MIE=0, MPIE=1; then mret -> MIE=1, MPIE=1; redirect_pc = mepc during mret.
- RW 344 with 0x5 -> csr_illegal=1, mip unchanged. RS 344 with csr_src_zero=1 -> csr_illegal=0, rdata = irq_pending. Address 0x7C0 -> csr_illegal=1.
- Same cycle: trap_valid plus RW 340 with 0xAB -> mscratch unchanged. Same cycle: mret plus RW 300 with 0 -> MIE takes MPIE.
- CSR_COUNTERS_EN: RW B00 with all-ones, then idle one cycle -> mcycle = 0 (wrap). Retire 3 cycles -> minstret = 3. Without the macro, read B00 -> csr_illegal=1.

Source files
------------

// File: rtl/csr_machine.sv
// Machine-mode CSR file for the RV64 core: CSR access, trap entry/mret update, redirect target.
// Optional mcycle/minstret counters are compiled in with `define CSR_COUNTERS_EN.
module csr_machine #(
   parameter int unsigned N        = 64,
   parameter logic [N-1:0] MISA_VAL = N'(64'h8000_0000_0000_0100)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   csr_op,
   input  logic [11:0]  csr_addr,
   input  logic [N-1:0] csr_wdata,
   input  logic         csr_src_zero,
   output logic [N-1:0] csr_rdata,
   output logic         csr_illegal,
   input  logic [N-1:0] irq_pending,
   input  logic         trap_valid,
   input  logic [N-1:0] trap_cause,
   input  logic [N-1:0] trap_pc,
   input  logic [N-1:0] trap_tval,
   input  logic         mret,
   input  logic         retire,
   output logic [N-1:0] redirect_pc,
   output logic         mstatus_mie,
   output logic [N-1:0] mie_out
);

   localparam logic [1:0]  OP_NONE = 2'b00;
   localparam logic [1:0]  OP_RW   = 2'b01;
   localparam logic [1:0]  OP_RS   = 2'b10;
   localparam logic [1:0]  OP_RC   = 2'b11;

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MISA     = 12'h301;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MHARTID  = 12'hF14;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02;

   localparam logic [N-1:0] LOW2_CLR = ~N'(3);

   logic         mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
   logic [N-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
   logic [N-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
   logic [N-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

   logic [N-1:0] mstatus_rd, wval, tvec_base;
   logic         known, read_only, wr_req, wr_en;

   always_comb begin
      mstatus_rd        = '0;
      mstatus_rd[3]     = mst_mie_q;
      mstatus_rd[7]     = mst_mpie_q;
      mstatus_rd[12:11] = 2'b11;
   end

   // Address decode and combinational read of the old value
   always_comb begin
      csr_rdata = '0;
      known     = 1'b1;
      read_only = 1'b0;
      case (csr_addr)
         A_MSTATUS:  csr_rdata = mstatus_rd;
         A_MISA:     begin csr_rdata = MISA_VAL; read_only = 1'b1; end
         A_MIE:      csr_rdata = mie_q;
         A_MTVEC:    csr_rdata = mtvec_q;
         A_MSCRATCH: csr_rdata = mscratch_q;
         A_MEPC:     csr_rdata = mepc_q;
         A_MCAUSE:   csr_rdata = mcause_q;
         A_MTVAL:    csr_rdata = mtval_q;
         A_MIP:      begin csr_rdata = irq_pending; read_only = 1'b1; end
         A_MHARTID:  read_only = 1'b1;
`ifdef CSR_COUNTERS_EN
         A_MCYCLE:   csr_rdata = mcycle_q;
         A_MINSTRET: csr_rdata = minstret_q;
`endif
         default:    known = 1'b0;
      endcase
   end

   // RS/RC from x0 or imm=0 are pure reads and therefore legal on read-only CSRs
   always_comb begin
      wr_req      = (csr_op == OP_RW) || (csr_op != OP_NONE && !csr_src_zero);
      csr_illegal = (csr_op != OP_NONE) && (!known || (read_only && wr_req));
      wr_en       = wr_req && known && !read_only && !trap_valid;
      case (csr_op)
         OP_RS:   wval = csr_rdata | csr_wdata;
         OP_RC:   wval = csr_rdata & ~csr_wdata;
         default: wval = csr_wdata;
      endcase
   end

   // Next state: trap suppresses mret and writes; mret overrides a write to mstatus
   always_comb begin
      mst_mie_d  = mst_mie_q;
      mst_mpie_d = mst_mpie_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      mcycle_d   = mcycle_q + N'(1);
      minstret_d = retire ? minstret_q + N'(1) : minstret_q;
      if (trap_valid) begin
         mepc_d     = trap_pc & LOW2_CLR;
         mcause_d   = trap_cause;
         mtval_d    = trap_tval;
         mst_mpie_d = mst_mie_q;
         mst_mie_d  = 1'b0;
      end else begin
         if (wr_en) begin
            case (csr_addr)
               A_MSTATUS:  begin mst_mie_d = wval[3]; mst_mpie_d = wval[7]; end
               A_MIE:      mie_d = wval;
               A_MTVEC:    mtvec_d = wval[1] ? (wval & LOW2_CLR) : wval;
               A_MSCRATCH: mscratch_d = wval;
               A_MEPC:     mepc_d = wval & LOW2_CLR;
               A_MCAUSE:   mcause_d = wval;
               A_MTVAL:    mtval_d = wval;
               A_MCYCLE:   mcycle_d = wval;
               A_MINSTRET: minstret_d = wval;
               default:    ;
            endcase
         end
         if (mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mst_mie_q  <= 1'b0;
         mst_mpie_q <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else begin
         mst_mie_q  <= mst_mie_d;
         mst_mpie_q <= mst_mpie_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
      end
   end

`ifdef CSR_COUNTERS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`else
   logic [2*N-1:0] unused_counters;
   assign mcycle_q        = '0;
   assign minstret_q      = '0;
   assign unused_counters = {mcycle_d, minstret_d};
`endif

   // Vectored mode offsets only interrupts; exceptions always go to the base
   always_comb begin
      tvec_base = mtvec_q & LOW2_CLR;
      if (!trap_valid)
         redirect_pc = mepc_q;
      else if (mtvec_q[1:0] == 2'b01 && trap_cause[N-1])
         redirect_pc = tvec_base + N'({trap_cause[5:0], 2'b00});
      else
         redirect_pc = tvec_base;
   end

   assign mstatus_mie = mst_mie_q;
   assign mie_out     = mie_q;

endmodule

// File: tb/tb_csr_machine.sv
// Self-checking bench for csr_machine: directed scenarios plus random traffic against a CSR model.
module tb_csr_machine;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [63:0] csr_wdata;
   logic        csr_src_zero;
   logic [63:0] csr_rdata;
   logic        csr_illegal;
   logic [63:0] irq_pending;
   logic        trap_valid;
   logic [63:0] trap_cause, trap_pc, trap_tval;
   logic        mret, retire;
   logic [63:0] redirect_pc;
   logic        mstatus_mie;
   logic [63:0] mie_out;

   csr_machine dut (
      .clk(clk), .reset(reset), .csr_op(csr_op), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .csr_src_zero(csr_src_zero), .csr_rdata(csr_rdata),
      .csr_illegal(csr_illegal), .irq_pending(irq_pending), .trap_valid(trap_valid),
      .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
      .mret(mret), .retire(retire), .redirect_pc(redirect_pc),
      .mstatus_mie(mstatus_mie), .mie_out(mie_out)
   );

   always #5 clk = ~clk;

   localparam logic [63:0] MISA = 64'h8000_0000_0000_0100;

   int n_cmp = 0;
   int n_fail = 0;

   // Architectural model state
   logic        m_mie, m_mpie;
   logic [63:0] m_mier, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle, m_minstret;
   logic [63:0] s_rdata, s_redirect;
   logic        s_illegal;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mie = 1'b0; m_mpie = 1'b0; m_mier = '0; m_mtvec = '0; m_mscratch = '0;
      m_mepc = '0; m_mcause = '0; m_mtval = '0; m_mcycle = '0; m_minstret = '0;
   endtask

   function automatic bit is_counter(input logic [11:0] a);
`ifdef CSR_COUNTERS_EN
      return a == 12'hB00 || a == 12'hB02;
`else
      return (a == 12'hB00 || a == 12'hB02) && 1'b0;
`endif
   endfunction

   function automatic bit is_ro(input logic [11:0] a);
      return a == 12'h301 || a == 12'h344 || a == 12'hF14;
   endfunction

   function automatic bit is_known(input logic [11:0] a);
      return is_ro(a) || is_counter(a) || a == 12'h300 || a == 12'h304 || a == 12'h305 ||
             (a >= 12'h340 && a <= 12'h343);
   endfunction

   function automatic logic [63:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 64'h1800 | (64'(m_mie) << 3) | (64'(m_mpie) << 7);
         12'h301: return MISA;
         12'h304: return m_mier;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return irq_pending;
         12'hB00: return m_mcycle;
         12'hB02: return m_minstret;
         default: return 64'h0;
      endcase
   endfunction

   // One clock: drive inputs, check combinational outputs mid-cycle, advance the model at the edge
   task automatic do_cycle(input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd,
                           input logic sz, input logic tv, input logic [63:0] tc,
                           input logic [63:0] tpc, input logic [63:0] ttv,
                           input logic mr, input logic rt);
      logic        wreq, ill, wok;
      logic [63:0] old, wv, base, exp_redir;
      csr_op = op; csr_addr = a; csr_wdata = wd; csr_src_zero = sz;
      trap_valid = tv; trap_cause = tc; trap_pc = tpc; trap_tval = ttv;
      mret = mr; retire = rt; irq_pending = {$urandom, $urandom};
      #1;
      old  = m_read(a);
      wreq = (op == 2'd1) || (op != 2'd0 && !sz);
      ill  = (op != 2'd0) && (!is_known(a) || (is_ro(a) && wreq));
      wok  = wreq && is_known(a) && !is_ro(a) && !tv;
      wv   = (op == 2'd2) ? (old | wd) : (op == 2'd3) ? (old & ~wd) : wd;
      base = {m_mtvec[63:2], 2'b00};
      if (!tv) exp_redir = m_mepc;
      else if (m_mtvec[1:0] == 2'b01 && tc[63]) exp_redir = base + 64'(tc[5:0]) * 64'd4;
      else exp_redir = base;
      s_rdata = csr_rdata; s_illegal = csr_illegal; s_redirect = redirect_pc;
      if (is_known(a)) chk("rdata", csr_rdata, old);
      chk("illegal", 64'(csr_illegal), 64'(ill));
      chk("redirect_pc", redirect_pc, exp_redir);
      chk("mstatus_mie", 64'(mstatus_mie), 64'(m_mie));
      chk("mie_out", mie_out, m_mier);
      @(posedge clk);
      m_mcycle = m_mcycle + 64'd1;
      if (rt) m_minstret = m_minstret + 64'd1;
      if (tv) begin
         m_mepc = tpc & ~64'h3; m_mcause = tc; m_mtval = ttv;
         m_mpie = m_mie; m_mie = 1'b0;
      end else begin
         if (wok) begin
            case (a)
               12'h300: if (!mr) begin m_mie = wv[3]; m_mpie = wv[7]; end
               12'h304: m_mier = wv;
               12'h305: m_mtvec = (wv & ~64'h3) | (wv[1] ? 64'h0 : (wv & 64'h1));
               12'h340: m_mscratch = wv;
               12'h341: m_mepc = wv & ~64'h3;
               12'h342: m_mcause = wv;
               12'h343: m_mtval = wv;
               12'hB00: m_mcycle = wv;
               12'hB02: m_minstret = wv;
               default: ;
            endcase
         end
         if (mr) begin m_mie = m_mpie; m_mpie = 1'b1; end
      end
      @(negedge clk);
   endtask

   task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd,
                      input logic sz);
      do_cycle(op, a, wd, sz, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
   endtask

   logic [11:0] addr_tab [14] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'h344, 12'hF14, 12'hB00, 12'hB02, 12'h7C0, 12'h000};

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] pend;
      reset = 1'b1; csr_op = 2'd0; csr_addr = 12'h300; csr_wdata = '0; csr_src_zero = 1'b0;
      irq_pending = '0; trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
      mret = 1'b0; retire = 1'b0;
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_mstatus", csr_rdata, 64'h1800);
      chk("rst_mstatus_mie", 64'(mstatus_mie), 64'h0);
      chk("rst_mie_out", mie_out, 64'h0);
      chk("rst_redirect", redirect_pc, 64'h0);
      chk("rst_illegal", 64'(csr_illegal), 64'h0);
      csr_addr = 12'hF14; #1 chk("rst_mhartid", csr_rdata, 64'h0);
      csr_addr = 12'h301; #1 chk("rst_misa", csr_rdata, MISA);
      @(negedge clk);
      reset = 1'b0;

      // Vectored interrupt trap
      csr(2'd1, 12'h305, 64'h8000_0101, 1'b0);
      do_cycle(2'd0, 12'h341, 64'h0, 1'b0, 1'b1, 64'h8000_0000_0000_0007, 64'h40, 64'h77, 1'b0, 1'b0);
      chk("vec_redirect", s_redirect, 64'h8000_011C);
      csr(2'd0, 12'h341, 64'h0, 1'b0);
      chk("trap_mepc", s_rdata, 64'h40);
      csr(2'd0, 12'h342, 64'h0, 1'b0);
      chk("trap_mcause", s_rdata, 64'h8000_0000_0000_0007);

      // MIE/MPIE stacking through trap and mret
      csr(2'd2, 12'h300, 64'h8, 1'b0);
      do_cycle(2'd0, 12'h300, 64'h0, 1'b0, 1'b1, 64'h2, 64'h83, 64'h0, 1'b0, 1'b0);
      chk("exc_redirect", s_redirect, 64'h8000_0100);
      csr(2'd0, 12'h300, 64'h0, 1'b0);
      chk("trap_mstatus", s_rdata, 64'h1880);
      do_cycle(2'd0, 12'h300, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
      chk("mret_redirect", s_redirect, 64'h80);
      csr(2'd0, 12'h300, 64'h0, 1'b0);
      chk("mret_mstatus", s_rdata, 64'h1888);

      // Read-only and unknown addresses
      csr(2'd1, 12'h344, 64'h5, 1'b0);
      chk("mip_rw_illegal", 64'(s_illegal), 64'h1);
      csr(2'd2, 12'h344, 64'h0, 1'b1);
      pend = irq_pending;
      chk("mip_rs0_legal", 64'(s_illegal), 64'h0);
      chk("mip_read", s_rdata, pend);
      csr(2'd1, 12'h7C0, 64'h1, 1'b0);
      chk("unknown_illegal", 64'(s_illegal), 64'h1);

      // Priority: trap blocks writes, mret beats mstatus write only
      csr(2'd1, 12'h340, 64'h11, 1'b0);
      do_cycle(2'd1, 12'h340, 64'hAB, 1'b0, 1'b1, 64'h5, 64'h100, 64'h0, 1'b0, 1'b0);
      csr(2'd0, 12'h340, 64'h0, 1'b0);
      chk("trap_blocks_write", s_rdata, 64'h11);
      do_cycle(2'd0, 12'h300, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
      do_cycle(2'd1, 12'h300, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
      csr(2'd0, 12'h300, 64'h0, 1'b0);
      chk("mret_beats_mstatus", s_rdata, 64'h1888);
      do_cycle(2'd1, 12'h340, 64'h55, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
      csr(2'd0, 12'h340, 64'h0, 1'b0);
      chk("mret_other_write", s_rdata, 64'h55);

      // WARL fields
      csr(2'd1, 12'h305, 64'h1234_5673, 1'b0);
      csr(2'd0, 12'h305, 64'h0, 1'b0);
      chk("mtvec_warl", s_rdata, 64'h1234_5670);
      csr(2'd1, 12'h341, 64'hFFFF, 1'b0);
      csr(2'd0, 12'h341, 64'h0, 1'b0);
      chk("mepc_warl", s_rdata, 64'hFFFC);
      csr(2'd1, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      csr(2'd3, 12'h300, 64'h8, 1'b0);
      chk("mstatus_warl", s_rdata, 64'h1888);

`ifdef CSR_COUNTERS_EN
      csr(2'd1, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      csr(2'd0, 12'h000, 64'h0, 1'b0);
      csr(2'd0, 12'hB00, 64'h0, 1'b0);
      chk("mcycle_wrap", s_rdata, 64'h0);
      csr(2'd1, 12'hB02, 64'h0, 1'b0);
      for (int i = 0; i < 3; i++) do_cycle(2'd0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
      csr(2'd0, 12'hB02, 64'h0, 1'b0);
      chk("minstret_count", s_rdata, 64'h3);
`else
      csr(2'd0, 12'hB00, 64'h0, 1'b0);
      chk("b00_read_idle", 64'(s_illegal), 64'h0);
      csr(2'd2, 12'hB00, 64'h0, 1'b1);
      chk("b00_illegal", 64'(s_illegal), 64'h1);
`endif

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         do_cycle(2'($urandom_range(0, 3)), addr_tab[$urandom_range(0, 13)], {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  {1'($urandom_range(0, 1)), 57'($urandom), 6'($urandom)},
                  {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset mid-operation
      csr(2'd1, 12'h304, 64'hFFFF, 1'b0);
      csr(2'd1, 12'h340, 64'hDEAD, 1'b0);
      csr(2'd1, 12'h341, 64'h1000, 1'b0);
      csr_op = 2'd1; csr_addr = 12'h340; csr_wdata = 64'h77;
      #2 reset = 1'b1;
      csr_op = 2'd0;
      #1;
      model_reset();
      chk("midrst_mscratch", csr_rdata, 64'h0);
      chk("midrst_mie_out", mie_out, 64'h0);
      chk("midrst_redirect", redirect_pc, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      csr(2'd0, 12'h300, 64'h0, 1'b0);
      chk("post_rst_mstatus", s_rdata, 64'h1800);
      for (int i = 0; i < 50; i++) begin
         do_cycle(2'($urandom_range(0, 3)), addr_tab[$urandom_range(0, 13)], {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
